// File: rtl/mbist_mem_collar.sv
// mbist_mem_collar: BIST/functional collar around a synchronous single-port RAM.
// Arbitrates array ownership, pipelines read data with rd_lat cycles of latency
// and applies a deterministic stuck-at fault on one configurable cell bit.
module mbist_mem_collar #(
   parameter int unsigned aw     = 4,
   parameter int unsigned dw     = 4,
   parameter int unsigned tcsw   = 2,
   parameter int unsigned rd_lat = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  test_en,
   input  logic [aw-1:0]         tas_in,
   input  logic [tcsw-1:0]       tcs_in,
   input  logic [dw-1:0]         tds_in,
   input  logic [aw-1:0]         func_addr,
   input  logic                  func_re,
   input  logic                  func_we,
   input  logic [dw-1:0]         func_wdata,
   output logic [dw-1:0]         func_rdata,
   output logic [dw-1:0]         mem_out,
   output logic                  mem_valid_out,
   output logic                  test_active_out,
   input  logic                  fi_en,
   input  logic [aw-1:0]         fi_addr,
   input  logic [$clog2(dw)-1:0] fi_bit,
   input  logic                  fi_val
);

   localparam int unsigned DEPTH = 2 ** aw;

   typedef enum logic [1:0] {
      ST_FUNC  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_TEST  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [dw-1:0]   mem_q [DEPTH];

   logic            own_test, own_func, rd_req, wr_req, fi_hit, pipe_empty;
   logic [aw-1:0]   acc_addr;
   logic [dw-1:0]   acc_wdata, fi_mask, fi_force, rd_data, wr_data;

   logic            rd0_v_q, rd0_v_d, rd0_bist_q, rd0_bist_d;
   logic [dw-1:0]   rd0_data_q, rd0_data_d;
   logic            rd1_v_q, rd1_v_d, rd1_bist_q, rd1_bist_d;
   logic [dw-1:0]   rd1_data_q, rd1_data_d;
   logic            res_v, res_bist;
   logic [dw-1:0]   res_data;

   logic [dw-1:0]   mem_out_q, mem_out_d, func_rdata_q, func_rdata_d;
   logic            mem_valid_q, mem_valid_d, test_active_q, test_active_d;

   // Ownership state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_FUNC;
      else     state_q <= state_d;
   end

   // Ownership next state: leave DRAIN only once no read is still in flight
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_FUNC:  if (test_en)  state_d = ST_DRAIN;
         ST_TEST:  if (!test_en) state_d = ST_DRAIN;
         ST_DRAIN: if (pipe_empty) state_d = test_en ? ST_TEST : ST_FUNC;
         default:  state_d = ST_FUNC;
      endcase
   end

   // Port select, access decode and fault overlay on both read and write data
   always_comb begin
      own_test  = (state_q == ST_TEST);
      own_func  = (state_q == ST_FUNC);
      rd_req    = 1'b0;
      wr_req    = 1'b0;
      acc_addr  = func_addr;
      acc_wdata = func_wdata;
      if (own_test) begin
         rd_req    = tcs_in[0];
         wr_req    = tcs_in[1];
         acc_addr  = tas_in;
         acc_wdata = tds_in;
      end else if (own_func) begin
         rd_req    = func_re;
         wr_req    = func_we;
      end
      fi_hit   = fi_en && (acc_addr == fi_addr) && (32'(fi_bit) < dw);
      fi_mask  = fi_hit ? (dw'(1) << fi_bit) : '0;
      fi_force = fi_val ? fi_mask : '0;
      rd_data  = (mem_q[acc_addr] & ~fi_mask) | fi_force;
      wr_data  = (acc_wdata & ~fi_mask) | fi_force;
   end

   // Array write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (!rst && wr_req) mem_q[acc_addr] <= wr_data;
   end

   // Read pipeline next values; each entry is tagged with the issuing port
   always_comb begin
      rd0_v_d    = rd_req;
      rd0_bist_d = own_test;
      rd0_data_d = rd_data;
      rd1_v_d    = rd0_v_q;
      rd1_bist_d = rd0_bist_q;
      rd1_data_d = rd0_data_q;
      pipe_empty = !rd0_v_q && ((rd_lat < 2) || !rd1_v_q);
   end

   // Output next values: route retiring read to its port, hold otherwise
   always_comb begin
      res_v         = rd0_v_q;
      res_bist      = rd0_bist_q;
      res_data      = rd0_data_q;
      if (rd_lat >= 2) begin
         res_v    = rd1_v_q;
         res_bist = rd1_bist_q;
         res_data = rd1_data_q;
      end
      test_active_d = (state_q == ST_TEST);
      mem_valid_d   = res_v && res_bist;
      mem_out_d     = (res_v && res_bist)  ? res_data : mem_out_q;
      func_rdata_d  = (res_v && !res_bist) ? res_data : func_rdata_q;
   end

   // Pipeline and output registers; reset drops any reads in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         rd0_v_q       <= 1'b0;
         rd0_bist_q    <= 1'b0;
         rd0_data_q    <= '0;
         rd1_v_q       <= 1'b0;
         rd1_bist_q    <= 1'b0;
         rd1_data_q    <= '0;
         mem_out_q     <= '0;
         mem_valid_q   <= 1'b0;
         func_rdata_q  <= '0;
         test_active_q <= 1'b0;
      end else begin
         rd0_v_q       <= rd0_v_d;
         rd0_bist_q    <= rd0_bist_d;
         rd0_data_q    <= rd0_data_d;
         rd1_v_q       <= rd1_v_d;
         rd1_bist_q    <= rd1_bist_d;
         rd1_data_q    <= rd1_data_d;
         mem_out_q     <= mem_out_d;
         mem_valid_q   <= mem_valid_d;
         func_rdata_q  <= func_rdata_d;
         test_active_q <= test_active_d;
      end
   end

   assign mem_out         = mem_out_q;
   assign mem_valid_out   = mem_valid_q;
   assign func_rdata      = func_rdata_q;
   assign test_active_out = test_active_q;

endmodule

// File: tb/tb_mbist_mem_collar.sv
// Bench for mbist_mem_collar: two instances (rd_lat 1 and 2) share stimulus and
// are compared every cycle against a transaction-level reference model.
module tb_mbist_mem_collar;

   logic       clk = 1'b0;
   logic       rst, test_en, f_re, f_we, fi_en, fi_val;
   logic [3:0] tas, tds, f_addr, f_wdata, fi_addr;
   logic [1:0] tcs, fi_bit;

   logic [3:0] mem_out_w [2];
   logic [3:0] func_rdata_w [2];
   logic       valid_w [2];
   logic       ta_w [2];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mbist_mem_collar #(.aw(4), .dw(4), .tcsw(2), .rd_lat(1)) u_dut0 (
      .clk(clk), .rst(rst), .test_en(test_en), .tas_in(tas), .tcs_in(tcs), .tds_in(tds),
      .func_addr(f_addr), .func_re(f_re), .func_we(f_we), .func_wdata(f_wdata),
      .func_rdata(func_rdata_w[0]), .mem_out(mem_out_w[0]), .mem_valid_out(valid_w[0]),
      .test_active_out(ta_w[0]), .fi_en(fi_en), .fi_addr(fi_addr), .fi_bit(fi_bit),
      .fi_val(fi_val));

   mbist_mem_collar #(.aw(4), .dw(4), .tcsw(2), .rd_lat(2)) u_dut1 (
      .clk(clk), .rst(rst), .test_en(test_en), .tas_in(tas), .tcs_in(tcs), .tds_in(tds),
      .func_addr(f_addr), .func_re(f_re), .func_we(f_we), .func_wdata(f_wdata),
      .func_rdata(func_rdata_w[1]), .mem_out(mem_out_w[1]), .mem_valid_out(valid_w[1]),
      .test_active_out(ta_w[1]), .fi_en(fi_en), .fi_addr(fi_addr), .fi_bit(fi_bit),
      .fi_val(fi_val));

   // Reference model: owner mode, memory image and reads scheduled by due cycle
   int         lat [2] = '{1, 2};
   int         cyc = 0;
   int         m_mode [2];      // 0 functional, 1 draining, 2 BIST
   int         m_last_rd [2];
   logic [3:0] m_mem [2][16];
   logic       s_v [2][4];
   logic       s_b [2][4];
   logic [3:0] s_d [2][4];
   logic [3:0] e_mem_out [2];
   logic [3:0] e_func [2];
   logic       e_valid [2];
   logic       e_ta [2];
   logic [3:0] init_val [16];

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_edge();
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_mode[k]    = 0;
            m_last_rd[k] = -100;
            for (int s = 0; s < 4; s++) s_v[k][s] = 1'b0;
            e_mem_out[k] = '0;
            e_func[k]    = '0;
            e_valid[k]   = 1'b0;
            e_ta[k]      = 1'b0;
         end else begin
            int         slot, nxt;
            logic       re, we, bist, hit;
            logic [3:0] a, wd, d;
            slot       = cyc % 4;
            e_valid[k] = 1'b0;
            if (s_v[k][slot]) begin
               if (s_b[k][slot]) begin
                  e_mem_out[k] = s_d[k][slot];
                  e_valid[k]   = 1'b1;
               end else begin
                  e_func[k] = s_d[k][slot];
               end
               s_v[k][slot] = 1'b0;
            end
            e_ta[k] = (m_mode[k] == 2);
            bist = (m_mode[k] == 2);
            re = bist ? tcs[0] : (m_mode[k] == 0) ? f_re : 1'b0;
            we = bist ? tcs[1] : (m_mode[k] == 0) ? f_we : 1'b0;
            a  = bist ? tas : f_addr;
            wd = bist ? tds : f_wdata;
            hit = fi_en && (a == fi_addr);
            if (re) begin
               d = m_mem[k][a];
               if (hit) d[fi_bit] = fi_val;
               nxt = (cyc + lat[k]) % 4;
               s_v[k][nxt] = 1'b1;
               s_b[k][nxt] = bist;
               s_d[k][nxt] = d;
               m_last_rd[k] = cyc;
            end
            if (we) begin
               if (hit) wd[fi_bit] = fi_val;
               m_mem[k][a] = wd;
            end
            if (m_mode[k] == 0 && test_en) m_mode[k] = 1;
            else if (m_mode[k] == 2 && !test_en) m_mode[k] = 1;
            else if (m_mode[k] == 1 && (cyc - m_last_rd[k]) > lat[k]) m_mode[k] = test_en ? 2 : 0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("mem_out[%0d]", k), 32'(mem_out_w[k]), 32'(e_mem_out[k]));
         check($sformatf("mem_valid[%0d]", k), 32'(valid_w[k]), 32'(e_valid[k]));
         check($sformatf("func_rdata[%0d]", k), 32'(func_rdata_w[k]), 32'(e_func[k]));
         check($sformatf("test_active[%0d]", k), 32'(ta_w[k]), 32'(e_ta[k]));
      end
   endtask

   task automatic idle();
      tcs  = 2'b00;
      f_re = 1'b0;
      f_we = 1'b0;
   endtask

   initial begin
      rst = 1'b1; test_en = 1'b0; idle();
      tas = '0; tds = '0; f_addr = '0; f_wdata = '0;
      fi_en = 1'b0; fi_addr = '0; fi_bit = '0; fi_val = 1'b0;
      step(); step();
      for (int k = 0; k < 2; k++) check("reset_ta", 32'(ta_w[k]), 32'd0);
      rst = 1'b0;

      // Load known contents through the functional port
      for (int a = 0; a < 16; a++) begin
         init_val[a] = 4'($urandom);
         f_we = 1'b1; f_addr = 4'(a); f_wdata = init_val[a];
         step();
      end
      idle(); step();

      // Ownership switch with an idle pipeline; functional write during DRAIN is dropped
      test_en = 1'b1; step();
      check("ta_n0", 32'(ta_w[0]), 32'd0);
      f_we = 1'b1; f_addr = 4'd5; f_wdata = ~init_val[5]; step();
      check("ta_n1", 32'(ta_w[0]), 32'd0);
      idle(); step();
      check("ta_n2", 32'(ta_w[0]), 32'd1);
      check("ta_n2_lat2", 32'(ta_w[1]), 32'd1);

      // Write then read-back latency on the rd_lat=1 instance
      tcs = 2'b10; tas = 4'd3; tds = 4'hA; step();
      tcs = 2'b01; tas = 4'd3; step();
      tcs = 2'b01; tas = 4'd5; step();
      check("wr_rd_data", 32'(mem_out_w[0]), 32'hA);
      check("wr_rd_valid", 32'(valid_w[0]), 32'd1);
      idle(); step();
      check("drain_we_ignored", 32'(mem_out_w[0]), 32'(init_val[5]));
      step();
      check("valid_drop", 32'(valid_w[0]), 32'd0);
      check("mem_out_hold", 32'(mem_out_w[0]), 32'(init_val[5]));

      // Read-then-write returns old data and stores new data
      tcs = 2'b10; tas = 4'd7; tds = 4'h5; step();
      tcs = 2'b11; tas = 4'd7; tds = 4'hF; step();
      tcs = 2'b01; tas = 4'd7; step();
      check("rmw_old", 32'(mem_out_w[0]), 32'h5);
      idle(); step();
      check("rmw_new", 32'(mem_out_w[0]), 32'hF);

      // Stuck-at-1 on bit 0 of address 2; neighbour cell unaffected
      fi_en = 1'b1; fi_addr = 4'd2; fi_bit = 2'd0; fi_val = 1'b1;
      tcs = 2'b10; tas = 4'd2; tds = 4'h0; step();
      tas = 4'd1; step();
      tcs = 2'b01; tas = 4'd2; step();
      tas = 4'd1; step();
      check("fi_hit", 32'(mem_out_w[0]), 32'h1);
      idle(); step();
      check("fi_miss", 32'(mem_out_w[0]), 32'h0);
      fi_en = 1'b0;
      tcs = 2'b01; tas = 4'd15; step();
      idle(); step();
      check("addr_wrap", 32'(mem_out_w[0]), 32'(init_val[15]));

      // rd_lat=2: read and drop test_en together; result still delivered
      tcs = 2'b01; tas = 4'd0; test_en = 1'b0; step();
      idle(); step();
      check("drain_rd_pending", 32'(valid_w[1]), 32'd0);
      step();
      check("drain_rd_valid", 32'(valid_w[1]), 32'd1);
      check("drain_rd_data", 32'(mem_out_w[1]), 32'(init_val[0]));
      step();
      f_re = 1'b1; f_addr = 4'd3; step();
      idle(); step(); step();
      check("func_after_drain0", 32'(func_rdata_w[0]), 32'hA);
      check("func_after_drain1", 32'(func_rdata_w[1]), 32'hA);

      // Reset one cycle after a BIST read suppresses its result
      test_en = 1'b1; repeat (4) step();
      check("test_again", 32'(ta_w[1]), 32'd1);
      tcs = 2'b01; tas = 4'd0; step();
      idle(); rst = 1'b1; test_en = 1'b0; step();
      rst = 1'b0; step();
      for (int k = 0; k < 2; k++) begin
         check("rst_valid", 32'(valid_w[k]), 32'd0);
         check("rst_mem_out", 32'(mem_out_w[k]), 32'd0);
         check("rst_func_rdata", 32'(func_rdata_w[k]), 32'd0);
         check("rst_ta", 32'(ta_w[k]), 32'd0);
      end

      // Randomized traffic with ownership toggles, faults and sporadic resets
      repeat (3000) begin
         rst     = ($urandom % 256) == 0;
         if (($urandom % 12) == 0) test_en = ~test_en;
         tcs     = 2'($urandom);
         tas     = 4'($urandom);
         tds     = 4'($urandom);
         f_re    = 1'($urandom);
         f_we    = 1'($urandom);
         f_addr  = 4'($urandom);
         f_wdata = 4'($urandom);
         fi_en   = ($urandom % 4) == 0;
         fi_addr = 4'($urandom);
         fi_bit  = 2'($urandom);
         fi_val  = 1'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mbist_mem_collar.md
# mbist_mem_collar

Memory-side collar that terminates the BIST test buses (TAS address, TCS control, TDS data) generated by the memory BIST controller and returns read data on the `mem` compare path. It wraps a synchronous single-port RAM array, arbitrates ownership between the functional port and the BIST port, and models the memory's read latency. It also provides a deterministic stuck-at fault injector, so the BIST pass/fail path can be exercised on the FPGA.

## Interface

Parameters:
- `aw`, 4, address width; must equal `ADDR_WIDTH`. Depth is 2^aw.
- `dw`, 4, data width; must equal `DATA_WIDTH`.
- `tcsw`, 2, TCS width. Bit 0 is read, bit 1 is write. Upper bits, if any, are ignored.
- `rd_lat`, 1, read latency in cycles. Legal values are 1 or 2.

Ports:
- `clk`  in  1  Single clock. All logic is on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `test_en`  in  1  Request for BIST ownership of the array.
- `tas_in`  in  aw  BIST address.
- `tcs_in`  in  tcsw  BIST operation: 00 nop, 01 read, 10 write, 11 read-then-write.
- `tds_in`  in  dw  BIST write data.
- `func_addr`  in  aw  Functional address.
- `func_re`  in  1  Functional read strobe.
- `func_we`  in  1  Functional write strobe.
- `func_wdata`  in  dw  Functional write data.
- `func_rdata`  out  dw  Functional read data.
- `mem_out`  out  dw  BIST read data, routed to the data comparator.
- `mem_valid_out`  out  1  `mem_out` carries a new BIST read result this cycle.
- `test_active_out`  out  1  BIST currently owns the array.
- `fi_en`  in  1  Enable the stuck-at fault.
- `fi_addr`  in  aw  Address of the faulty cell.
- `fi_bit`  in  clog2(dw)  Bit index of the faulty cell.
- `fi_val`  in  1  Stuck-at value (0 or 1).

## Operation

Ownership state machine:
- States are FUNC (reset state), DRAIN, and TEST.
- FUNC -> DRAIN when `test_en`=1.
- TEST -> DRAIN when `test_en`=0.
- DRAIN -> the target owner once the read pipeline is empty: no read issued in the last `rd_lat` cycles.
- If `test_en` toggles back during DRAIN, the target is re-evaluated. Pipeline rules still apply.
- `test_active_out` is 1 only in TEST.
- In DRAIN, both ports are ignored: no array access.

Port gating:
- In TEST, `func_re`/`func_we` are ignored and `func_rdata` holds its last value.
- In FUNC, `tcs_in` is ignored and `mem_valid_out` stays 0.

BIST operations (in TEST):
- Read: data at `tas_in` is returned on `mem_out` after `rd_lat` cycles, with `mem_valid_out`=1 for exactly that cycle.
- Write: `tds_in` is stored at `tas_in`.
- 11 (read-then-write): returns the OLD contents on `mem_out` and stores `tds_in` in the same cycle. This supports a march r0/w1 element in one cycle.
- Back-to-back operations are accepted every cycle. There is no stall and no backpressure.
- A write followed by a read of the same address on the next cycle returns the new data.

Functional port:
- Same semantics as the BIST port, with `func_re`/`func_we` in place of TCS bits 0/1.
- `func_re` and `func_we` together behave as read-then-write.

Fault injection:
- When `fi_en`=1, any write to `fi_addr` stores bit `fi_bit` as `fi_val`.
- Any read of `fi_addr` returns bit `fi_bit` forced to `fi_val`, independent of stored contents.
- `fi_*` is sampled at the operation's issue cycle.
- An `fi_bit` value ≥ dw disables the fault.

Reset:
- State returns to FUNC.
- `mem_out`, `func_rdata` = 0; `mem_valid_out`, `test_active_out` = 0.
- Reads in flight are discarded.
- Array contents are not cleared; they are undefined after power-up.

## Timing

- An operation issued at edge N returns read data at edge N+`rd_lat`, so data is visible during cycle N+`rd_lat`.
- `mem_out` holds its value between valid cycles.
- `rd_lat`=2 adds one output register stage. Throughput stays 1 operation per cycle.
- Switching ownership costs at least 1 DRAIN cycle and at most `rd_lat`+1.
- `test_en` asserted at edge N with an idle pipeline gives `test_active_out`=1 at N+2.
- Reset asserted mid-read suppresses that read's `mem_valid_out`.
- Address wrap: `tas_in` = 2^aw-1 is the last cell. There is no out-of-range case.

## Test plan

- Ownership switch: reset, then `test_en`=1 with no traffic -> `test_active_out` rises exactly 2 cycles later. A `func_we` issued during DRAIN leaves the array unchanged.
- Write/read latency: with `rd_lat`=1, write 0xA to addr 3, then read addr 3 -> `mem_out`=0xA and `mem_valid_out`=1 exactly 1 cycle after the read, then 0.
- Read-then-write: store 0x5 at addr 7, then issue tcs=11 with tds=0xF -> returns 0x5. A following read of addr 7 returns 0xF.
- Stuck-at fault: `fi_en`=1, `fi_addr`=2, `fi_bit`=0, `fi_val`=1; write 0x0 to addr 2 and read -> 0x1. Addr 1 read after writing 0x0 -> 0x0.
- Drain and reset: with `rd_lat`=2, read addr 0 and drop `test_en` the same cycle -> the read result still appears, then state goes to FUNC. Repeat with `rst` pulsed one cycle after the read -> no `mem_valid_out`, all outputs 0.
